// File: rtl/bldc_adc_spi_resp_pkg.sv
// Shared definitions for the BLDC ADC SPI responder.
//   state_t        : handshake/frame FSM states
//   frame constants: slot layout of the MCP3208-class 19-slot SPI frame
//   mosi_bit()     : command bit driven on MOSI for a given slot
package bldc_adc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        RESP,
        GAP
    } state_t;

    localparam int FRAME_SLOTS     = 19;
    localparam int CMD_SLOTS       = 5;
    localparam int NULL_SLOT       = 6;
    localparam int DATA_FIRST_SLOT = NULL_SLOT + 1;
    localparam int DATA_BITS       = 12;
    localparam int NUM_EXT_CH      = 8;

    // Slots 0/1 carry the start and single-ended bits, slots 2..4 the
    // channel number MSB first; everything after the command is driven low.
    function automatic logic mosi_bit(input logic [4:0] slot, input logic [2:0] ch);
        logic b;
        b = 1'b0;
        if (slot < 5'(CMD_SLOTS)) begin
            case (slot)
                5'd0, 5'd1: b = 1'b1;
                5'd2:       b = ch[2];
                5'd3:       b = ch[1];
                5'd4:       b = ch[0];
                default:    b = 1'b0;
            endcase
        end
        return b;
    endfunction

endpackage

// File: rtl/bldc_adc_spi_resp_if.sv
// Command/response stream between the BLDC ADC reading controller (master)
// and the SPI responder (slave).
//   cmd_vld_i/cmd_ch_i/cmd_sop_i/cmd_eop_i : command from controller
//   cmd_ready_o                             : responder can accept
//   rsp_vld_o                               : one-cycle response strobe
//   rsp_ch_o/rsp_data_o/rsp_sop_o/rsp_eop_o : response fields (held)
interface bldc_adc_spi_resp_if;

    logic        cmd_vld_i;
    logic [4:0]  cmd_ch_i;
    logic        cmd_sop_i;
    logic        cmd_eop_i;
    logic        cmd_ready_o;
    logic        rsp_vld_o;
    logic [4:0]  rsp_ch_o;
    logic [11:0] rsp_data_o;
    logic        rsp_sop_o;
    logic        rsp_eop_o;

    modport master (
        output cmd_vld_i, cmd_ch_i, cmd_sop_i, cmd_eop_i,
        input  cmd_ready_o,
        input  rsp_vld_o, rsp_ch_o, rsp_data_o, rsp_sop_o, rsp_eop_o
    );

    modport slave (
        input  cmd_vld_i, cmd_ch_i, cmd_sop_i, cmd_eop_i,
        output cmd_ready_o,
        output rsp_vld_o, rsp_ch_o, rsp_data_o, rsp_sop_o, rsp_eop_o
    );

endinterface

// File: rtl/bldc_adc_spi_resp_shift.sv
// SPI frame engine: clock divider, slot counter, SCLK/MOSI generation,
// MISO synchronizer and result shift register.
//   clk, rst   : system clock, synchronous active-high reset
//   state      : current FSM state of the top (selects what to generate)
//   start      : pulse on the accepting edge; latches the channel
//   ch         : external channel number 0..7
//   miso       : asynchronous serial data from the ADC
//   sclk, mosi : registered SPI pin drivers
//   div_tc     : last clk of a divider period (SETUP/SHIFT/HOLD/GAP)
//   frame_end  : last clk of the final slot
//   done       : last clk of HOLD
//   data       : assembled 12-bit conversion result
module bldc_adc_spi_shift
    import bldc_adc_pkg::*;
#(
    parameter int CLK_DIV = 13
) (
    input  logic                 clk,
    input  logic                 rst,
    input  state_t               state,
    input  logic                 start,
    input  logic [2:0]           ch,
    input  logic                 miso,
    output logic                 sclk,
    output logic                 mosi,
    output logic                 div_tc,
    output logic                 frame_end,
    output logic                 done,
    output logic [DATA_BITS-1:0] data
);

    localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [4:0] LAST_SLOT  = 5'(FRAME_SLOTS - 1);
    localparam logic [4:0] FIRST_DATA = 5'(DATA_FIRST_SLOT);

    logic [7:0]           div_cnt;
    logic [4:0]           slot;
    logic [2:0]           ch_q;
    logic                 miso_m;
    logic                 miso_s;
    logic [DATA_BITS-1:0] shreg;
    logic                 counting;
    logic                 slot_end;

    // The divider also times GAP so the top needs no second counter.
    assign counting  = (state == SETUP) || (state == SHIFT) ||
                       (state == HOLD)  || (state == GAP);
    assign div_tc    = counting && (div_cnt == DIV_LAST);
    // A slot ends on the last clk of its sclk-high half.
    assign slot_end  = (state == SHIFT) && div_tc && sclk;
    assign frame_end = slot_end && (slot == LAST_SLOT);
    assign done      = (state == HOLD) && div_tc;
    assign data      = shreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            slot    <= '0;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
        end else begin
            div_cnt <= (!counting || div_tc) ? 8'd0 : div_cnt + 8'd1;

            if (state == SHIFT)
                sclk <= div_tc ? ~sclk : sclk;
            else
                sclk <= 1'b0;

            if (state != SHIFT)
                slot <= '0;
            else if (slot_end && !frame_end)
                slot <= slot + 5'd1;

            // MOSI moves only at slot boundaries, where sclk is going low;
            // slot 0 is presented as SETUP hands over to SHIFT.
            if (state == SETUP)
                mosi <= div_tc ? mosi_bit(5'd0, ch_q) : 1'b0;
            else if (state == SHIFT) begin
                if (slot_end)
                    mosi <= mosi_bit(slot + 5'd1, ch_q);
            end else
                mosi <= 1'b0;
        end
    end

    // Data path: channel latch, 2-flop MISO synchronizer, result shifter.
    // Slots up to the null bit are clocked past without capture.
    always_ff @(posedge clk) begin
        if (start)
            ch_q <= ch;
        miso_m <= miso;
        miso_s <= miso_m;
        if (slot_end && (slot >= FIRST_DATA))
            shreg <= {shreg[DATA_BITS-2:0], miso_s};
    end

endmodule

// File: rtl/bldc_adc_spi_resp.sv
// BLDC ADC responder: accepts one command at a time, runs one SPI
// conversion on an 8-channel 12-bit ADC and returns a one-cycle response.
//   clk, rst     : system clock, synchronous active-high reset
//   bus          : command/response stream (slave side)
//   adc_cs_n_o   : SPI chip select, active low
//   adc_sclk_o   : SPI clock, idle low
//   adc_mosi_o   : SPI data to ADC
//   adc_miso_i   : SPI data from ADC (asynchronous)
module bldc_adc_spi_resp
    import bldc_adc_pkg::*;
#(
    parameter int CLK_DIV = 13
) (
    input  logic                clk,
    input  logic                rst,
    bldc_adc_spi_resp_if.slave  bus,
    output logic                adc_cs_n_o,
    output logic                adc_sclk_o,
    output logic                adc_mosi_o,
    input  logic                adc_miso_i
);

    state_t               state;
    state_t               state_nxt;
    logic                 accept;
    logic                 ch_ok;
    logic [4:0]           ch_q;
    logic                 sop_q;
    logic                 eop_q;
    logic                 cs_n;
    logic                 div_tc;
    logic                 frame_end;
    logic                 spi_done;
    logic [DATA_BITS-1:0] spi_data;

    logic                 rsp_vld;
    logic [4:0]           rsp_ch;
    logic [11:0]          rsp_data;
    logic                 rsp_sop;
    logic                 rsp_eop;

    assign accept = bus.cmd_vld_i && (state == IDLE);
    assign ch_ok  = bus.cmd_ch_i < 5'(NUM_EXT_CH);

    bldc_adc_spi_shift #(
        .CLK_DIV (CLK_DIV)
    ) u_shift (
        .clk       (clk),
        .rst       (rst),
        .state     (state),
        .start     (accept && ch_ok),
        .ch        (bus.cmd_ch_i[2:0]),
        .miso      (adc_miso_i),
        .sclk      (adc_sclk_o),
        .mosi      (adc_mosi_o),
        .div_tc    (div_tc),
        .frame_end (frame_end),
        .done      (spi_done),
        .data      (spi_data)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Out-of-range channels never touch the pins: straight to RESP.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.cmd_vld_i) state_nxt = ch_ok ? SETUP : RESP;
            SETUP:   if (div_tc)        state_nxt = SHIFT;
            SHIFT:   if (frame_end)     state_nxt = HOLD;
            HOLD:    if (spi_done)      state_nxt = RESP;
            RESP:                       state_nxt = GAP;
            GAP:     if (div_tc)        state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            ch_q  <= bus.cmd_ch_i;
            sop_q <= bus.cmd_sop_i;
            eop_q <= bus.cmd_eop_i;
        end
    end

    // Response fields load only when entering RESP and then hold. An
    // invalid-channel command enters RESP on its own accepting edge, so
    // its fields come straight from the command inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_n     <= 1'b1;
            rsp_vld  <= 1'b0;
            rsp_ch   <= '0;
            rsp_data <= '0;
            rsp_sop  <= 1'b0;
            rsp_eop  <= 1'b0;
        end else begin
            cs_n    <= !((state_nxt == SETUP) || (state_nxt == SHIFT) ||
                         (state_nxt == HOLD));
            rsp_vld <= (state_nxt == RESP);
            if (state_nxt == RESP) begin
                if (state == IDLE) begin
                    rsp_ch   <= bus.cmd_ch_i;
                    rsp_data <= '0;
                    rsp_sop  <= bus.cmd_sop_i;
                    rsp_eop  <= bus.cmd_eop_i;
                end else begin
                    rsp_ch   <= ch_q;
                    rsp_data <= spi_data;
                    rsp_sop  <= sop_q;
                    rsp_eop  <= eop_q;
                end
            end
        end
    end

    assign bus.cmd_ready_o = (state == IDLE);
    assign bus.rsp_vld_o   = rsp_vld;
    assign bus.rsp_ch_o    = rsp_ch;
    assign bus.rsp_data_o  = rsp_data;
    assign bus.rsp_sop_o   = rsp_sop;
    assign bus.rsp_eop_o   = rsp_eop;
    assign adc_cs_n_o      = cs_n;

endmodule

// File: tb/tb_bldc_adc_spi_resp.sv
// Directed bench for bldc_adc_spi_resp with CLK_DIV=4 and a behavioural
// MCP3208-style ADC model driving MISO one clk after each SCLK fall.
module tb_bldc_adc_spi_resp;

    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic adc_cs_n;
    logic adc_sclk;
    logic adc_mosi;
    logic adc_miso = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    bldc_adc_spi_resp_if bus();

    bldc_adc_spi_resp #(
        .CLK_DIV (D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .adc_cs_n_o (adc_cs_n),
        .adc_sclk_o (adc_sclk),
        .adc_mosi_o (adc_mosi),
        .adc_miso_i (adc_miso)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- ADC model ----------------
    logic [11:0] adc_q[$];
    logic [11:0] cur_word = '0;
    logic [4:0]  mosi_log = '0;
    logic [4:0]  last_mosi = '0;
    logic        cs_prev = 1'b1;
    logic        sclk_prev = 1'b0;
    logic        miso_pend = 1'b0;
    logic        miso_next = 1'b0;
    bit          rand_pre = 1'b0;
    int          rise_cnt = 0;
    int          fall_cnt = 0;
    int          last_rises = 0;
    int          cs_hi_cnt = 0;
    int          last_gap = 0;
    int          toggles = 0;

    always @(negedge clk) begin
        if (miso_pend) begin
            adc_miso  = miso_next;
            miso_pend = 1'b0;
        end
        if (adc_cs_n !== cs_prev || adc_sclk !== sclk_prev)
            toggles++;
        if (!adc_cs_n && cs_prev) begin
            cur_word = (adc_q.size() > 0) ? adc_q.pop_front() : 12'h000;
            rise_cnt = 0;
            fall_cnt = 0;
            mosi_log = '0;
            last_gap = cs_hi_cnt;
            adc_miso = rand_pre ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        if (adc_cs_n && !cs_prev) begin
            last_rises = rise_cnt;
            last_mosi  = mosi_log;
            cs_hi_cnt  = 0;
        end
        if (adc_cs_n)
            cs_hi_cnt++;
        if (!adc_cs_n) begin
            if (adc_sclk && !sclk_prev) begin
                if (rise_cnt < 5)
                    mosi_log[4-rise_cnt] = adc_mosi;
                rise_cnt++;
            end
            if (!adc_sclk && sclk_prev) begin
                fall_cnt++;
                miso_pend = 1'b1;
                if (fall_cnt >= 7 && fall_cnt <= 18)
                    miso_next = cur_word[18-fall_cnt];
                else
                    miso_next = rand_pre ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
        cs_prev   = adc_cs_n;
        sclk_prev = adc_sclk;
    end

    // ---------------- stimulus helpers ----------------
    // Presents a command and returns t, the cyc value after the accepting edge.
    task automatic accept_cmd(input logic [4:0] ch, input logic sop, input logic eop,
                              input bit hold, output int t);
        bit found;
        @(negedge clk);
        bus.cmd_vld_i = 1'b1;
        bus.cmd_ch_i  = ch;
        bus.cmd_sop_i = sop;
        bus.cmd_eop_i = eop;
        found = 1'b0;
        t = -1;
        for (int i = 0; i < 600 && !found; i++) begin
            if (bus.cmd_ready_o === 1'b1) found = 1'b1;
            else @(negedge clk);
        end
        if (!found) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: cmd_ready_o=%b required 1", bus.cmd_ready_o);
        end else begin
            t = cyc + 1;
            @(negedge clk);
        end
        if (!hold) bus.cmd_vld_i = 1'b0;
    endtask

    // Returns the cyc value at which rsp_vld_o is seen high.
    task automatic wait_rsp(output int r);
        bit found;
        found = 1'b0;
        r = -1;
        for (int i = 0; i < 600 && !found; i++) begin
            if (bus.rsp_vld_o === 1'b1) begin found = 1'b1; r = cyc; end
            else @(negedge clk);
        end
        if (!found) begin
            n_cmp++; n_bad++;
            $display("FAIL rsp_timeout: rsp_vld_o never rose");
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (bus.cmd_ready_o !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", bus.cmd_ready_o); end
        n_cmp++; if (adc_cs_n !== 1'b1)        begin n_bad++; $display("FAIL rst_cs_n: got %b want 1", adc_cs_n); end
        n_cmp++; if (adc_sclk !== 1'b0)        begin n_bad++; $display("FAIL rst_sclk: got %b want 0", adc_sclk); end
        n_cmp++; if (adc_mosi !== 1'b0)        begin n_bad++; $display("FAIL rst_mosi: got %b want 0", adc_mosi); end
        n_cmp++; if (bus.rsp_vld_o !== 1'b0)   begin n_bad++; $display("FAIL rst_rsp_vld: got %b want 0", bus.rsp_vld_o); end
        n_cmp++; if (bus.rsp_data_o !== 12'h0) begin n_bad++; $display("FAIL rst_rsp_data: got %h want 000", bus.rsp_data_o); end
        n_cmp++; if (bus.rsp_ch_o !== 5'd0)    begin n_bad++; $display("FAIL rst_rsp_ch: got %0d want 0", bus.rsp_ch_o); end
    endtask

    task automatic test_single();
        int t, r;
        rand_pre = 1'b0;
        adc_q.push_back(12'hA5C);
        accept_cmd(5'd3, 1'b1, 1'b1, 1'b0, t);
        wait_rsp(r);
        n_cmp++; if (r - t != 160)                begin n_bad++; $display("FAIL single_latency: got %0d want 160", r - t); end
        n_cmp++; if (bus.rsp_ch_o !== 5'd3)       begin n_bad++; $display("FAIL single_ch: got %0d want 3", bus.rsp_ch_o); end
        n_cmp++; if (bus.rsp_data_o !== 12'hA5C)  begin n_bad++; $display("FAIL single_data: got %h want a5c", bus.rsp_data_o); end
        n_cmp++; if (bus.rsp_sop_o !== 1'b1)      begin n_bad++; $display("FAIL single_sop: got %b want 1", bus.rsp_sop_o); end
        n_cmp++; if (bus.rsp_eop_o !== 1'b1)      begin n_bad++; $display("FAIL single_eop: got %b want 1", bus.rsp_eop_o); end
        @(negedge clk);
        n_cmp++; if (bus.rsp_vld_o !== 1'b0)      begin n_bad++; $display("FAIL single_pulse_width: got %b want 0", bus.rsp_vld_o); end
        n_cmp++; if (bus.rsp_data_o !== 12'hA5C)  begin n_bad++; $display("FAIL single_data_hold: got %h want a5c", bus.rsp_data_o); end
        @(negedge clk);
        n_cmp++; if (last_mosi !== 5'b11011)      begin n_bad++; $display("FAIL single_mosi_cmd: got %b want 11011", last_mosi); end
        n_cmp++; if (last_rises != 19)            begin n_bad++; $display("FAIL single_sclk_rises: got %0d want 19", last_rises); end
    endtask

    task automatic test_back_to_back();
        int t1, r1, r2, rdy;
        bit found;
        rand_pre = 1'b0;
        adc_q.push_back(12'h000);
        adc_q.push_back(12'hFFF);
        accept_cmd(5'd0, 1'b1, 1'b0, 1'b1, t1);
        bus.cmd_ch_i  = 5'd7;
        bus.cmd_sop_i = 1'b0;
        bus.cmd_eop_i = 1'b1;
        wait_rsp(r1);
        n_cmp++; if (r1 - t1 != 160)              begin n_bad++; $display("FAIL b2b_latency1: got %0d want 160", r1 - t1); end
        n_cmp++; if (bus.rsp_data_o !== 12'h000)  begin n_bad++; $display("FAIL b2b_data1: got %h want 000", bus.rsp_data_o); end
        n_cmp++; if (bus.rsp_ch_o !== 5'd0)       begin n_bad++; $display("FAIL b2b_ch1: got %0d want 0", bus.rsp_ch_o); end
        // Second command is taken in the first cycle cmd_ready_o is back high.
        found = 1'b0;
        rdy = -1;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (bus.cmd_ready_o === 1'b1) begin found = 1'b1; rdy = cyc; end
        end
        n_cmp++; if (rdy - t1 != 165)             begin n_bad++; $display("FAIL b2b_accept_gap: got %0d want 165", rdy - t1); end
        @(negedge clk);
        bus.cmd_vld_i = 1'b0;
        wait_rsp(r2);
        n_cmp++; if (r2 - (rdy + 1) != 160)       begin n_bad++; $display("FAIL b2b_latency2: got %0d want 160", r2 - (rdy + 1)); end
        n_cmp++; if (bus.rsp_data_o !== 12'hFFF)  begin n_bad++; $display("FAIL b2b_data2: got %h want fff", bus.rsp_data_o); end
        n_cmp++; if (bus.rsp_ch_o !== 5'd7)       begin n_bad++; $display("FAIL b2b_ch2: got %0d want 7", bus.rsp_ch_o); end
        n_cmp++; if (bus.rsp_sop_o !== 1'b0)      begin n_bad++; $display("FAIL b2b_sop2: got %b want 0", bus.rsp_sop_o); end
        n_cmp++; if (bus.rsp_eop_o !== 1'b1)      begin n_bad++; $display("FAIL b2b_eop2: got %b want 1", bus.rsp_eop_o); end
        n_cmp++; if (last_gap < 4)                begin n_bad++; $display("FAIL b2b_cs_high_gap: got %0d want >=4", last_gap); end
    endtask

    task automatic test_invalid_channel();
        int t, r, tg0;
        @(negedge clk);
        tg0 = toggles;
        accept_cmd(5'd9, 1'b0, 1'b1, 1'b0, t);
        wait_rsp(r);
        n_cmp++; if (r != t)                      begin n_bad++; $display("FAIL inv_latency: got %0d want 0", r - t); end
        n_cmp++; if (bus.rsp_data_o !== 12'h000)  begin n_bad++; $display("FAIL inv_data: got %h want 000", bus.rsp_data_o); end
        n_cmp++; if (bus.rsp_ch_o !== 5'd9)       begin n_bad++; $display("FAIL inv_ch: got %0d want 9", bus.rsp_ch_o); end
        n_cmp++; if (bus.rsp_sop_o !== 1'b0)      begin n_bad++; $display("FAIL inv_sop: got %b want 0", bus.rsp_sop_o); end
        n_cmp++; if (bus.rsp_eop_o !== 1'b1)      begin n_bad++; $display("FAIL inv_eop: got %b want 1", bus.rsp_eop_o); end
        while (cyc < t + D) @(negedge clk);
        n_cmp++; if (bus.cmd_ready_o !== 1'b0)    begin n_bad++; $display("FAIL inv_gap_ready: got %b want 0", bus.cmd_ready_o); end
        @(negedge clk);
        n_cmp++; if (bus.cmd_ready_o !== 1'b1)    begin n_bad++; $display("FAIL inv_ready_back: got %b want 1", bus.cmd_ready_o); end
        @(negedge clk);
        n_cmp++; if (toggles != tg0)              begin n_bad++; $display("FAIL inv_pin_activity: got %0d toggles want 0", toggles - tg0); end
    endtask

    task automatic test_reset_mid_shift();
        int t, pulses;
        bit found;
        rand_pre = 1'b0;
        adc_q.push_back(12'h3C3);
        accept_cmd(5'd5, 1'b1, 1'b1, 1'b0, t);
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (fall_cnt == 10 && !adc_cs_n) found = 1'b1;
            else @(negedge clk);
        end
        n_cmp++; if (!found) begin n_bad++; $display("FAIL mid_reach_slot10: got fall_cnt=%0d want 10", fall_cnt); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (adc_cs_n !== 1'b1)           begin n_bad++; $display("FAIL mid_cs_n: got %b want 1", adc_cs_n); end
        n_cmp++; if (adc_sclk !== 1'b0)           begin n_bad++; $display("FAIL mid_sclk: got %b want 0", adc_sclk); end
        n_cmp++; if (adc_mosi !== 1'b0)           begin n_bad++; $display("FAIL mid_mosi: got %b want 0", adc_mosi); end
        n_cmp++; if (bus.cmd_ready_o !== 1'b1)    begin n_bad++; $display("FAIL mid_ready: got %b want 1", bus.cmd_ready_o); end
        pulses = 0;
        for (int i = 0; i < 200; i++) begin
            if (bus.rsp_vld_o === 1'b1) pulses++;
            @(negedge clk);
        end
        n_cmp++; if (pulses != 0)                 begin n_bad++; $display("FAIL mid_no_response: got %0d pulses want 0", pulses); end
    endtask

    task automatic test_random_miso();
        int t, r;
        logic [11:0] w;
        logic [4:0]  ch;
        rand_pre = 1'b1;
        for (int n = 0; n < 100; n++) begin
            w  = 12'($urandom);
            ch = 5'($urandom_range(0, 7));
            adc_q.push_back(w);
            accept_cmd(ch, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, t);
            wait_rsp(r);
            n_cmp++; if (bus.rsp_data_o !== w) begin n_bad++; $display("FAIL rand_data[%0d]: got %h want %h", n, bus.rsp_data_o, w); end
            n_cmp++; if (bus.rsp_ch_o !== ch)  begin n_bad++; $display("FAIL rand_ch[%0d]: got %0d want %0d", n, bus.rsp_ch_o, ch); end
        end
        rand_pre = 1'b0;
    endtask

    initial begin
        bus.cmd_vld_i = 1'b0;
        bus.cmd_ch_i  = '0;
        bus.cmd_sop_i = 1'b0;
        bus.cmd_eop_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_invalid_channel();
        test_reset_mid_shift();
        test_random_miso();
        test_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bldc_adc_spi_resp.md
Name: bldc_adc_spi_resp

Overview:
- Responder end of the BLDC ADC command/response stream (cmd_vld/cmd_ch/cmd_sop/cmd_eop/cmd_ready in; rsp_vld/rsp_ch/rsp_data/rsp_sop/rsp_eop out).
- Serves each accepted command with one conversion from an external 8-channel 12-bit SPI ADC (MCP3208-class frame), then returns a one-cycle response.
- Sits between the BLDC ADC reading controller and the chip pins; replaces the vendor ADC IP on targets without one.

Parameters:
- CLK_DIV, 13, clk cycles per SCLK half-period (SCLK = clk/(2*CLK_DIV)); legal range 3..255.

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  reset
- cmd_vld_i  in  1  command valid
- cmd_ch_i  in  5  command channel
- cmd_sop_i  in  1  command start-of-packet
- cmd_eop_i  in  1  command end-of-packet
- cmd_ready_o  out  1  command ready
- rsp_vld_o  out  1  response valid, single-cycle pulse, no backpressure
- rsp_ch_o  out  5  response channel (echo of cmd_ch)
- rsp_data_o  out  12  conversion result
- rsp_sop_o  out  1  echo of cmd_sop
- rsp_eop_o  out  1  echo of cmd_eop
- adc_cs_n_o  out  1  SPI chip select, active low
- adc_sclk_o  out  1  SPI clock, idle low
- adc_mosi_o  out  1  SPI data to ADC
- adc_miso_i  in  1  SPI data from ADC, asynchronous

Behaviour:
- Clocking and reset (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - cmd_ready_o=1, rsp_vld_o=0, rsp_ch_o=0, rsp_data_o=0, rsp_sop_o=0, rsp_eop_o=0.
  - adc_cs_n_o=1, adc_sclk_o=0, adc_mosi_o=0, state=IDLE.
- Accept: a command is accepted on a clk edge where cmd_vld_i & cmd_ready_o. At that edge ch/sop/eop are latched and cmd_ready_o drops.
  - cmd_ready_o is high only in IDLE.
  - cmd_vld_i outside IDLE is ignored; the initiator holds the command until accepted.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> RESP -> GAP -> IDLE.
  - SETUP: cs_n=0, sclk=0, lasts CLK_DIV clks.
  - SHIFT: 19 bit slots, each 2*CLK_DIV clks. First CLK_DIV clks sclk=0, next CLK_DIV clks sclk=1.
  - HOLD: cs_n=0, sclk=0, lasts CLK_DIV clks.
  - RESP: cs_n=1, rsp_vld_o=1 for exactly 1 clk.
  - GAP: cs_n=1, lasts CLK_DIV clks (minimum CS-high time). Then IDLE.
- Frame, slot k=0..18:
  - MOSI per slot: k=0 start '1'; k=1 single-ended '1'; k=2..4 ch[2:0] MSB first; k>=5 drive 0.
  - MOSI changes only at slot start, while sclk low.
  - k=5 is the sample period; k=6 is the null bit, which is ignored.
  - k=7..18 carry B11..B0, MSB first.
  - adc_miso_i passes through a 2-flop synchronizer. The synchronized value is captured on the last clk of each slot's sclk-high phase.
- Latency: acceptance edge T -> rsp_vld_o high in the cycle after edge T+40*CLK_DIV. cmd_ready_o is high again after edge T+41*CLK_DIV+1.
- Response fields:
  - rsp_ch/sop/eop equal the latched command; rsp_data is the assembled 12 bits.
  - All rsp_* fields hold their value until the next RESP; only rsp_vld_o pulses.
- Invalid channel (cmd_ch_i[4:3] != 0): skip SETUP/SHIFT/HOLD. cs_n stays 1 and there is no sclk activity. Go straight to RESP with rsp_data=0, then GAP.
- Reset mid-operation (any state): on the next edge cs_n=1, sclk=0, mosi=0, state=IDLE, cmd_ready_o=1. The frame is aborted and no response is emitted.
- Counters:
  - Divider counter: 8 bits, wraps at CLK_DIV-1.
  - Slot counter: 5 bits, terminal at 18.
  - Shift register: 12 bits.
  - No arithmetic overflow is possible within the legal CLK_DIV range.

Decomposition:
- Package bldc_adc_pkg holds:
  - the state enum;
  - constants FRAME_SLOTS=19, CMD_SLOTS=5, NULL_SLOT=6, DATA_FIRST_SLOT=7, DATA_BITS=12, NUM_EXT_CH=8.
- One sub-module, bldc_adc_spi_shift: divider, slot counter, MOSI/SCLK generation, MISO sync and capture.
  - Interface: start pulse, ch[2:0]; outputs done pulse and data[11:0].
  - The top keeps the handshake FSM and response registers.

Test Plan:
- Reset: assert rst for 2 clks mid-idle -> cmd_ready_o=1, cs_n=1, sclk=0, rsp_vld_o=0, rsp_data_o=0.
- Single command, CLK_DIV=4: ch=3, sop=1, eop=1, ADC model returns 12'hA5C.
  - MOSI slots 0..4 must read 1,1,0,1,1.
  - Exactly 19 sclk rising edges.
  - rsp_vld_o=1 for 1 clk, 160 clks after acceptance, with rsp_ch=3, rsp_data=12'hA5C, sop=1, eop=1.
- Back-to-back, CLK_DIV=4: cmd_vld_i held high with ch=0 then ch=7 (model data 12'h000, then 12'hFFF).
  - Second command is accepted 165 clks after the first.
  - Responses are 12'h000/ch0 and 12'hFFF/ch7.
  - cs_n is high for ≥4 clks between frames.
- Invalid channel: ch=9 -> no cs_n/sclk toggling; rsp_vld_o in the cycle after the acceptance edge with rsp_data=0, rsp_ch=9.
- Reset during SHIFT slot 10 -> next edge cs_n=1, sclk=0, cmd_ready_o=1; no rsp_vld_o pulse within the following 200 clks.
- MISO timing margin: model changes MISO 1 clk after each sclk falling edge with random data -> every captured word matches the model over 100 commands.
